// File: rtl/red_pitaya_dfilt_pkg.sv
// red_pitaya_dfilt_pkg: shared widths, shifts, latency and coefficient record for the DAC pre-emphasis filter
package red_pitaya_dfilt_pkg;
    localparam int DW_DEF = 14;
    localparam int PP_W   = 25;
    localparam int AA_W   = 18;
    localparam int KK_W   = 25;
    localparam int PP_SH  = 16;
    localparam int AA_SH  = 18;
    localparam int KK_SH  = 24;
    localparam int ACC_W  = 24;
    localparam int LAT    = 4;
    localparam logic [KK_W-1:0] KK_UNITY = KK_W'(1) << KK_SH;

    typedef struct packed {
        logic signed [PP_W-1:0] pp;
        logic [AA_W-1:0]        aa;
        logic [KK_W-1:0]        kk;
    } coef_t;
endpackage

// File: rtl/red_pitaya_sat.sv
// red_pitaya_sat: signed saturation from IW to OW bits with a clip flag
module red_pitaya_sat #(
    parameter int IW = 25,
    parameter int OW = 24
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 clip
);
    logic [IW-OW:0] top;

    // the value fits when all bits above the output sign bit agree with it
    always_comb begin
        top  = din[IW-1:OW-1];
        clip = !((&top) || !(|top));
        dout = clip ? {din[IW-1], {(OW-1){~din[IW-1]}}} : din[OW-1:0];
    end
endmodule

// File: rtl/red_pitaya_dfilt_dac.sv
// red_pitaya_dfilt_dac: pre-emphasis / single-pole DAC filter with gain, bypass and clip counter
module red_pitaya_dfilt_dac
    import red_pitaya_dfilt_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int SCW = 16
) (
    input  logic                   dac_clk_i,
    input  logic                   dac_rstn_i,
    input  logic signed [DW-1:0]   dac_dat_i,
    input  logic                   dac_vld_i,
    output logic signed [DW-1:0]   dac_dat_o,
    output logic                   dac_vld_o,
    input  logic signed [PP_W-1:0] cfg_pp_i,
    input  logic [AA_W-1:0]        cfg_aa_i,
    input  logic [KK_W-1:0]        cfg_kk_i,
    input  logic                   cfg_upd_i,
    input  logic                   cfg_byp_i,
    input  logic                   sat_clr_i,
    output logic [SCW-1:0]         sat_cnt_o
);
    localparam int DDW = DW + 1;
    localparam int EPW = PP_W + DDW;
    localparam int EW  = EPW + 1;
    localparam int APW = AA_W + 1 + ACC_W;
    localparam int IW  = APW + 1;
    localparam int KPW = KK_W + 1 + ACC_W;

    coef_t                    coef, s1_c;
    logic                     byp_r;
    logic [LAT-1:0]           vld_sr;
    logic signed [DW-1:0]     x_prev, s1_x;
    logic signed [DDW-1:0]    s1_d;
    logic                     s1_byp, s2_byp, s3_byp;
    logic signed [ACC_W-1:0]  s2_e, s3_i, i_prev;
    logic [AA_W-1:0]          s2_aa;
    logic [KK_W-1:0]          s2_kk, s3_kk;

    logic signed [EPW-1:0]    e_prod, e_sh;
    logic signed [EW-1:0]     e_sum;
    logic signed [APW-1:0]    a_prod, a_sh;
    logic signed [IW-1:0]     i_dif;
    logic signed [KPW-1:0]    k_prod, k_sh;
    logic signed [ACC_W-1:0]  e_sat, i_sat, e_nxt, i_nxt;
    logic signed [DW-1:0]     y_sat, y_nxt;
    logic                     y_clip, e_clip_unused, i_clip_unused;

    // datapath arithmetic; widths are wide enough that only the saturators lose information
    always_comb begin
        e_prod = EPW'($signed(s1_c.pp)) * EPW'(s1_d);
        e_sh   = e_prod >>> PP_SH;
        e_sum  = EW'(e_sh) + EW'(s1_x);
        a_prod = APW'($signed({1'b0, s2_aa})) * APW'(i_prev);
        a_sh   = a_prod >>> AA_SH;
        i_dif  = IW'(s2_e) - IW'(a_sh);
        k_prod = KPW'($signed({1'b0, s3_kk})) * KPW'(s3_i);
        k_sh   = k_prod >>> KK_SH;
        e_nxt  = s1_byp ? ACC_W'(s1_x) : e_sat;
        i_nxt  = s2_byp ? s2_e : i_sat;
        y_nxt  = s3_byp ? DW'(s3_i) : y_sat;
    end

    red_pitaya_sat #(.IW(EW), .OW(ACC_W)) u_sat_e (.din(e_sum), .dout(e_sat), .clip(e_clip_unused));
    red_pitaya_sat #(.IW(IW), .OW(ACC_W)) u_sat_i (.din(i_dif), .dout(i_sat), .clip(i_clip_unused));
    red_pitaya_sat #(.IW(KPW), .OW(DW))   u_sat_y (.din(k_sh),  .dout(y_sat), .clip(y_clip));

    // active coefficients and bypass mode, both taking effect for samples accepted after the edge
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            coef  <= '{pp: '0, aa: '0, kk: KK_UNITY};
            byp_r <= 1'b0;
        end else begin
            if (cfg_upd_i) coef <= '{pp: cfg_pp_i, aa: cfg_aa_i, kk: cfg_kk_i};
            byp_r <= cfg_byp_i;
        end
    end

    // valid shift register; reset empties the pipeline so in-flight samples are dropped
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) vld_sr <= '0;
        else             vld_sr <= {vld_sr[LAT-2:0], dac_vld_i};
    end

    // stage 1: difference against the previous sample, snapshot coefficients and mode with the sample
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            x_prev <= '0;
            s1_x   <= '0;
            s1_d   <= '0;
            s1_byp <= 1'b0;
            s1_c   <= '0;
        end else if (dac_vld_i) begin
            x_prev <= byp_r ? '0 : dac_dat_i;
            s1_x   <= dac_dat_i;
            s1_d   <= DDW'(dac_dat_i) - DDW'(x_prev);
            s1_byp <= byp_r;
            s1_c   <= coef;
        end
    end

    // stage 2: pre-emphasis sum
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            s2_e   <= '0;
            s2_byp <= 1'b0;
            s2_aa  <= '0;
            s2_kk  <= '0;
        end else if (vld_sr[0]) begin
            s2_e   <= e_nxt;
            s2_byp <= s1_byp;
            s2_aa  <= s1_c.aa;
            s2_kk  <= s1_c.kk;
        end
    end

    // stage 3: single-pole feedback closed within this cycle
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            s3_i   <= '0;
            i_prev <= '0;
            s3_byp <= 1'b0;
            s3_kk  <= '0;
        end else if (vld_sr[1]) begin
            s3_i   <= i_nxt;
            i_prev <= s2_byp ? '0 : i_nxt;
            s3_byp <= s2_byp;
            s3_kk  <= s2_kk;
        end
    end

    // stage 4: gain, output register and clip counter (clear wins but still counts a coincident clip)
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            dac_dat_o <= '0;
            sat_cnt_o <= '0;
        end else begin
            if (vld_sr[2]) dac_dat_o <= y_nxt;
            if (vld_sr[2] && !s3_byp && y_clip)
                sat_cnt_o <= sat_clr_i ? SCW'(1) : (&sat_cnt_o ? sat_cnt_o : sat_cnt_o + 1'b1);
            else if (sat_clr_i)
                sat_cnt_o <= '0;
        end
    end

    assign dac_vld_o = vld_sr[LAT-1];
endmodule

// File: tb/tb_red_pitaya_dfilt_dac.sv
// tb_red_pitaya_dfilt_dac: table-driven directed checks of the DAC filter
module tb_red_pitaya_dfilt_dac;
    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [13:0] dat_i;
    logic               vld_i;
    logic signed [13:0] dat_o;
    logic               vld_o;
    logic signed [24:0] cfg_pp;
    logic [17:0]        cfg_aa;
    logic [24:0]        cfg_kk;
    logic               cfg_upd, cfg_byp, sat_clr;
    logic [15:0]        sat_cnt;

    typedef struct {
        bit v;
        bit u;
        bit b;
        int x;
        int y;
    } vec_t;

    vec_t tv[$];
    int   nchk = 0;
    int   nerr = 0;
    int   last_y = 0;

    always #5 clk = ~clk;

    red_pitaya_dfilt_dac dut (
        .dac_clk_i (clk),
        .dac_rstn_i(rst_n),
        .dac_dat_i (dat_i),
        .dac_vld_i (vld_i),
        .dac_dat_o (dat_o),
        .dac_vld_o (vld_o),
        .cfg_pp_i  (cfg_pp),
        .cfg_aa_i  (cfg_aa),
        .cfg_kk_i  (cfg_kk),
        .cfg_upd_i (cfg_upd),
        .cfg_byp_i (cfg_byp),
        .sat_clr_i (sat_clr),
        .sat_cnt_o (sat_cnt)
    );

    task automatic chk(input string nm, input int idx, input logic signed [31:0] act, input logic signed [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit v, input int x, input int y, input bit u = 1'b0, input bit b = 1'b0);
        tv.push_back('{v: v, u: u, b: b, x: x, y: y});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld_i = 1'b0; dat_i = '0; cfg_upd = 1'b0; cfg_byp = 1'b0; sat_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_y = 0;
    endtask

    task automatic set_cfg(input int pp, input int aa, input int kk);
        @(negedge clk);
        cfg_pp = 25'(pp); cfg_aa = 18'(aa); cfg_kk = 25'(kk); cfg_upd = 1'b1;
        @(negedge clk);
        cfg_upd = 1'b0;
    endtask

    // output of the sample driven in iteration j is visible just after the edge of iteration j+3
    task automatic run(input string nm);
        int n = tv.size();
        for (int j = 0; j < n + 4; j++) begin
            @(negedge clk);
            vld_i   = j < n ? tv[j].v : 1'b0;
            dat_i   = j < n ? 14'(tv[j].x) : '0;
            cfg_upd = j < n ? tv[j].u : 1'b0;
            cfg_byp = j < n ? tv[j].b : 1'b0;
            @(posedge clk);
            #1;
            if (j >= 3 && j - 3 < n && tv[j-3].v) begin
                chk({nm, "_vld"}, j - 3, 32'(vld_o), 1);
                chk({nm, "_dat"}, j - 3, 32'(dat_o), tv[j-3].y);
                last_y = tv[j-3].y;
            end else begin
                chk({nm, "_vld_idle"}, j, 32'(vld_o), 0);
                chk({nm, "_hold"}, j, 32'(dat_o), last_y);
            end
        end
        tv.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vld_i = 1'b0; dat_i = '0;
        cfg_pp = '0; cfg_aa = '0; cfg_kk = '0; cfg_upd = 1'b0; cfg_byp = 1'b0; sat_clr = 1'b0;
        do_reset();
        #1;
        chk("rst_vld", 0, 32'(vld_o), 0);
        chk("rst_dat", 0, 32'(dat_o), 0);
        chk("rst_sat", 0, 32'(sat_cnt), 0);

        // default coefficients: pass-through ramp
        for (int i = 0; i <= 100; i++) add(1, i, i);
        run("ramp");

        // full pre-emphasis on a step
        do_reset();
        set_cfg(65536, 0, 1 << 24);
        add(1, 0, 0); add(1, 0, 0); add(1, 1000, 2000);
        add(1, 1000, 1000); add(1, 1000, 1000); add(1, 1000, 1000);
        run("step");

        // pole at -0.5 on an impulse, with valid gaps that must not disturb the state
        do_reset();
        set_cfg(0, 131072, 1 << 24);
        add(1, 1024, 1024); add(1, 0, -512); add(0, 777, 0); add(1, 0, 256);
        add(0, -3, 0); add(0, 5, 0); add(1, 0, -128); add(1, 0, 64); add(1, 0, -32);
        run("pole");

        // gain of almost 2 clips at both rails
        do_reset();
        set_cfg(0, 0, (1 << 25) - 1);
        add(1, 8191, 8191); add(1, 8191, 8191); add(1, 8191, 8191);
        add(1, 100, 199); add(1, -5000, -8192);
        run("gain");
        chk("sat_cnt_after_gain", 0, 32'(sat_cnt), 4);

        @(negedge clk); sat_clr = 1'b1;
        @(posedge clk); #1;
        chk("sat_clr_only", 0, 32'(sat_cnt), 0);
        @(negedge clk); sat_clr = 1'b0; vld_i = 1'b1; dat_i = 14'sd8191;
        @(negedge clk); vld_i = 1'b0; dat_i = '0;
        @(negedge clk);
        @(negedge clk); sat_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_clip_vld", 0, 32'(vld_o), 1);
        chk("clr_clip_dat", 0, 32'(dat_o), 8191);
        chk("clr_clip_cnt", 0, 32'(sat_cnt), 1);
        last_y = 8191;
        @(negedge clk);
        @(posedge clk); #1;
        chk("clr_again_cnt", 0, 32'(sat_cnt), 0);
        @(negedge clk); sat_clr = 1'b0;

        // bypassed samples are not scaled and never counted
        add(1, 0, 0, 0, 1); add(1, 8191, 8191, 0, 1); add(1, 0, 0);
        run("byp_nocnt");
        chk("sat_cnt_byp", 0, 32'(sat_cnt), 0);

        // coefficient update coincident with a sample applies to the following sample
        do_reset();
        cfg_pp = '0; cfg_aa = '0; cfg_kk = 25'(1 << 23);
        add(1, 1000, 1000, 1); add(1, 1000, 500); add(1, -600, -300);
        run("upd");

        // reset with three samples in flight
        @(negedge clk); vld_i = 1'b1; dat_i = 14'sd11;
        @(negedge clk); dat_i = 14'sd22;
        @(negedge clk); dat_i = 14'sd33;
        @(negedge clk); vld_i = 1'b0; dat_i = '0; rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 0, 32'(vld_o), 0);
        chk("mid_rst_dat", 0, 32'(dat_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_y = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("post_rst_vld", k, 32'(vld_o), 0);
        end

        // bypass toggled mid-stream switches only at sample boundaries
        do_reset();
        set_cfg(65536, 0, 1 << 24);
        add(1, 0, 0, 0, 0); add(1, 500, 1000, 0, 1); add(1, 600, 600, 0, 1);
        add(1, 700, 700, 0, 0); add(1, 700, 1400); add(1, 700, 700);
        run("byp_toggle");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
